// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman job arbiter slice.
// Symbol encoding, job geometry and the arbiter state enum live here.
package sw_pkg;

    localparam int LEN_REF         = 64;
    localparam int LEN_QUERY       = 48;
    localparam int WIDTH_SCORE     = 8;
    localparam int WIDTH_POS_REF   = 7;
    localparam int WIDTH_POS_QUERY = 6;
    localparam int ADDR_W          = 6;

    typedef enum logic [1:0] {
        SYM_A = 2'd0,
        SYM_C = 2'd1,
        SYM_G = 2'd2,
        SYM_T = 2'd3
    } sym_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_STREAM,
        ST_GAP,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/sw_rr_arb2.sv
// Two-requester round-robin pick: the requester served last loses a tie.
// Purely combinational; the caller registers the result.
module sw_rr_arb2 (
    input  logic [1:0] req,
    input  logic [0:0] last,
    output logic [1:0] gnt
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last[0] ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sw_job_arbiter.sv
// Arbitrates two requesters onto one SW core: streams the winner's symbols,
// waits for the core result under a watchdog, and returns it with a done pulse.
module sw_job_arbiter
    import sw_pkg::*;
#(
    parameter int WIDTH_SCORE     = sw_pkg::WIDTH_SCORE,
    parameter int WIDTH_POS_REF   = sw_pkg::WIDTH_POS_REF,
    parameter int WIDTH_POS_QUERY = sw_pkg::WIDTH_POS_QUERY,
    parameter int LEN_REF         = sw_pkg::LEN_REF,
    parameter int LEN_QUERY       = sw_pkg::LEN_QUERY,
    parameter int TIMEOUT         = 4095
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req,
    input  logic [1:0][1:0]            req_ref,
    input  logic [1:0][1:0]            req_qry,
    output logic [1:0]                 gnt,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [1:0]                 done,
    output logic                       err,
    output logic [WIDTH_SCORE-1:0]     res_max,
    output logic [WIDTH_POS_REF-1:0]   res_pos_ref,
    output logic [WIDTH_POS_QUERY-1:0] res_pos_query,
    output logic                       sw_valid,
    output logic [1:0]                 sw_data_ref,
    output logic [1:0]                 sw_data_query,
    input  logic                       sw_finish,
    input  logic [WIDTH_SCORE-1:0]     sw_max,
    input  logic [WIDTH_POS_REF-1:0]   sw_pos_ref,
    input  logic [WIDTH_POS_QUERY-1:0] sw_pos_query
);

    localparam int                 WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(LEN_REF - 1);
    localparam logic [ADDR_W:0]    QRY_END   = (ADDR_W + 1)'(LEN_QUERY);
    // WAIT lasts exactly TIMEOUT cycles: abort in the cycle whose increment brings the count to TIMEOUT.
    localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [0:0]        last_srv;
    logic [1:0]        arb_gnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              sel;
    logic              timeout_hit;

    assign sel         = gnt[1];
    assign timeout_hit = (wd_cnt == WD_LAST);

    sw_rr_arb2 u_arb (
        .req  (req),
        .last (last_srv),
        .gnt  (arb_gnt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sw_valid      = 1'b0;
        sw_data_ref   = 2'b00;
        sw_data_query = 2'b00;
        done          = 2'b00;
        case (state)
            ST_IDLE:   if (req != 2'b00) state_nxt = ST_GRANT;
            ST_GRANT:  state_nxt = ST_STREAM;
            ST_STREAM: begin
                sw_valid    = 1'b1;
                sw_data_ref = req_ref[sel];
                if ({1'b0, rd_addr} < QRY_END) sw_data_query = req_qry[sel];
                if (rd_addr == ADDR_LAST) state_nxt = ST_GAP;
            end
            ST_GAP:    state_nxt = ST_WAIT;
            ST_WAIT:   if (sw_finish || timeout_hit) state_nxt = ST_RESP;
            ST_RESP: begin
                done      = gnt;
                state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt           <= 2'b00;
            last_srv      <= 1'b1;
            rd_addr       <= '0;
            wd_cnt        <= '0;
            err           <= 1'b0;
            res_max       <= '0;
            res_pos_ref   <= '0;
            res_pos_query <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req != 2'b00) gnt <= arb_gnt;
                ST_STREAM: begin
                    if (rd_addr == ADDR_LAST) rd_addr <= '0;
                    else                      rd_addr <= rd_addr + 1'b1;
                end
                ST_GAP: wd_cnt <= '0;
                ST_WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (sw_finish) begin
                        res_max       <= sw_max;
                        res_pos_ref   <= sw_pos_ref;
                        res_pos_query <= sw_pos_query;
                        err           <= 1'b0;
                    end else if (timeout_hit) begin
                        res_max       <= '0;
                        res_pos_ref   <= '0;
                        res_pos_query <= '0;
                        err           <= 1'b1;
                    end
                end
                ST_RESP: begin
                    last_srv <= gnt[1];
                    gnt      <= 2'b00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sw_job_arbiter.sv
// Self-checking bench for sw_job_arbiter: directed job table, a hand-written
// mid-stream reset sequence, and randomized jobs against a job-level model.
module tb_sw_job_arbiter;

    localparam int LEN_REF   = 64;
    localparam int LEN_QUERY = 48;
    localparam int TIMEOUT   = 4095;
    localparam int PAT_ZERO  = 0;
    localparam int PAT_ADDR  = 1;
    localparam int PAT_RAND  = 2;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      req   = 2'b00;
    logic [1:0][1:0] req_ref;
    logic [1:0][1:0] req_qry;
    logic [1:0]      gnt;
    logic [5:0]      rd_addr;
    logic [1:0]      done;
    logic            err;
    logic [7:0]      res_max;
    logic [6:0]      res_pos_ref;
    logic [5:0]      res_pos_query;
    logic            sw_valid;
    logic [1:0]      sw_data_ref;
    logic [1:0]      sw_data_query;
    logic            sw_finish    = 1'b0;
    logic [7:0]      sw_max       = '1;
    logic [6:0]      sw_pos_ref   = '1;
    logic [5:0]      sw_pos_query = '1;

    // Requester symbol memories and SW core model controls.
    logic [1:0] ref_mem [2][LEN_REF];
    logic [1:0] qry_mem [2][LEN_REF];
    int         core_delay = 0;
    int         stray_addr = -1;
    int         cm_cnt     = -1;
    logic [7:0] core_max   = 8'h00;
    logic [6:0] core_pref  = 7'h00;
    logic [5:0] core_pq    = 6'h00;
    int         last_srv   = 1;
    int         checks     = 0;
    int         errors     = 0;

    typedef struct {
        bit         pre_reset;
        logic [1:0] req;
        int         pat;
        int         delay;
        int         stray;
        bit         hold;
        logic [1:0] exp_gnt;
        bit         exp_err;
    } vec_t;

    vec_t vecs [7];

    sw_job_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_ref       (req_ref),
        .req_qry       (req_qry),
        .gnt           (gnt),
        .rd_addr       (rd_addr),
        .done          (done),
        .err           (err),
        .res_max       (res_max),
        .res_pos_ref   (res_pos_ref),
        .res_pos_query (res_pos_query),
        .sw_valid      (sw_valid),
        .sw_data_ref   (sw_data_ref),
        .sw_data_query (sw_data_query),
        .sw_finish     (sw_finish),
        .sw_max        (sw_max),
        .sw_pos_ref    (sw_pos_ref),
        .sw_pos_query  (sw_pos_query)
    );

    always #5 clk = ~clk;

    assign req_ref[0] = ref_mem[0][rd_addr];
    assign req_ref[1] = ref_mem[1][rd_addr];
    assign req_qry[0] = qry_mem[0][rd_addr];
    assign req_qry[1] = qry_mem[1][rd_addr];

    // SW core model: finishes core_delay cycles after its last input beat (0 = never);
    // outside a real finish it drives all-ones garbage on the result bus.
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            cm_cnt       = -1;
            sw_finish    = 1'b0;
            sw_max       = '1;
            sw_pos_ref   = '1;
            sw_pos_query = '1;
        end else begin
            sw_finish    = 1'b0;
            sw_max       = '1;
            sw_pos_ref   = '1;
            sw_pos_query = '1;
            if (sw_valid) begin
                cm_cnt = 0;
                if (int'(rd_addr) == stray_addr) sw_finish = 1'b1;
            end else if (cm_cnt >= 0) begin
                cm_cnt++;
                if (cm_cnt == core_delay) begin
                    sw_finish    = 1'b1;
                    sw_max       = core_max;
                    sw_pos_ref   = core_pref;
                    sw_pos_query = core_pq;
                    cm_cnt       = -1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] rr_pick(input logic [1:0] r, input int last);
        if (r == 2'b11) return (last == 1) ? 2'b01 : 2'b10;
        return r;
    endfunction

    task automatic fill_mem(input int pat);
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < LEN_REF; a++) begin
                case (pat)
                    PAT_ADDR: begin ref_mem[i][a] = 2'(a % 4); qry_mem[i][a] = 2'd3; end
                    PAT_RAND: begin
                        ref_mem[i][a] = 2'($urandom_range(0, 3));
                        qry_mem[i][a] = 2'($urandom_range(0, 3));
                    end
                    default:  begin ref_mem[i][a] = 2'd0; qry_mem[i][a] = 2'd0; end
                endcase
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        last_srv = 1;
        @(negedge clk);
    endtask

    // Runs one job from an IDLE-cycle negedge and returns at the negedge of the following IDLE cycle.
    task automatic run_job(input logic [1:0] req_v, input int delay, input int stray, input bit hold,
                           input logic [1:0] exp_gnt, input bit exp_err, input int pat);
        int         w;
        int         cyc;
        int         beats;
        int         bad_addr;
        int         bad_data;
        int         q_nz;
        int         exp_cyc;
        bit         seen;
        logic [1:0] done_v;
        logic       err_v;
        logic [1:0] exp_q;
        logic [7:0] rm;
        logic [6:0] rpr;
        logic [5:0] rpq;
        logic [7:0] em;
        logic [6:0] epr;
        logic [5:0] epq;

        core_delay = delay;
        stray_addr = stray;
        core_max   = 8'($urandom_range(1, 254));
        core_pref  = 7'($urandom_range(1, 126));
        core_pq    = 6'($urandom_range(1, 62));
        em  = exp_err ? 8'h00 : core_max;
        epr = exp_err ? 7'h00 : core_pref;
        epq = exp_err ? 6'h00 : core_pq;
        req = req_v;

        @(negedge clk);
        check("grant", {30'd0, gnt}, {30'd0, exp_gnt});
        check("grant_cycle_idle_bus", {25'd0, sw_valid, rd_addr}, 32'd0);
        w = (exp_gnt == 2'b10) ? 1 : 0;
        cyc = 1; beats = 0; bad_addr = 0; bad_data = 0; q_nz = 0; seen = 1'b0;
        done_v = 2'b00; err_v = 1'b0; rm = '0; rpr = '0; rpq = '0;

        for (int c = 0; c < LEN_REF + TIMEOUT + 16; c++) begin
            @(negedge clk);
            cyc++;
            if (sw_valid) begin
                if (int'(rd_addr) != beats) bad_addr++;
                if (beats < LEN_REF) begin
                    exp_q = (beats < LEN_QUERY) ? qry_mem[w][beats] : 2'b00;
                    if (sw_data_ref !== ref_mem[w][beats] || sw_data_query !== exp_q) bad_data++;
                end
                if (sw_data_query != 2'b00) q_nz++;
                beats++;
            end
            if (done != 2'b00) begin
                seen = 1'b1; done_v = done; err_v = err;
                rm = res_max; rpr = res_pos_ref; rpq = res_pos_query;
                break;
            end
        end

        exp_cyc = 1 + LEN_REF + 1 + (exp_err ? TIMEOUT : delay - 1) + 1;
        check("done_seen", {31'd0, seen}, 32'd1);
        check("done_target", {30'd0, done_v}, {30'd0, exp_gnt});
        check("valid_beats", beats, LEN_REF);
        check("addr_sequence_errors", bad_addr, 0);
        check("stream_data_errors", bad_data, 0);
        if (pat == PAT_ADDR) check("query_nonzero_beats", q_nz, LEN_QUERY);
        check("job_latency", cyc, exp_cyc);
        check("err", {31'd0, err_v}, {31'd0, exp_err});
        check("res_max", {24'd0, rm}, {24'd0, em});
        check("res_pos_ref", {25'd0, rpr}, {25'd0, epr});
        check("res_pos_query", {26'd0, rpq}, {26'd0, epq});

        last_srv = w;
        if (!hold) req = 2'b00;
        @(negedge clk);
        check("done_single_pulse_gnt_clear", {28'd0, done, gnt}, 32'd0);
        check("result_hold", {16'd0, err, res_max, res_pos_ref}, {16'd0, exp_err, em, epr});
    endtask

    initial begin
        int         n;
        int         dn;
        logic [1:0] r;
        int         d;
        int         s;

        vecs[0] = '{1'b0, 2'b01, PAT_ZERO, 3075, -1, 1'b0, 2'b01, 1'b0};
        vecs[1] = '{1'b1, 2'b11, PAT_ADDR,    5, -1, 1'b1, 2'b01, 1'b0};
        vecs[2] = '{1'b0, 2'b11, PAT_ADDR,    2, -1, 1'b1, 2'b10, 1'b0};
        vecs[3] = '{1'b0, 2'b11, PAT_ADDR,    9, -1, 1'b0, 2'b01, 1'b0};
        vecs[4] = '{1'b0, 2'b10, PAT_RAND,    0, -1, 1'b0, 2'b10, 1'b1};
        vecs[5] = '{1'b0, 2'b01, PAT_RAND,   40, 20, 1'b0, 2'b01, 1'b0};
        vecs[6] = '{1'b0, 2'b11, PAT_RAND,    2, 63, 1'b0, 2'b10, 1'b0};

        fill_mem(PAT_ZERO);
        repeat (2) @(negedge clk);
        check("reset_gnt_done_err", {27'd0, gnt, done, err}, 32'd0);
        check("reset_results", {11'd0, res_max, res_pos_ref, res_pos_query}, 32'd0);
        check("reset_stream_bus", {21'd0, rd_addr, sw_valid, sw_data_ref, sw_data_query}, 32'd0);
        reset    = 1'b0;
        last_srv = 1;
        @(negedge clk);
        check("idle_after_reset", {29'd0, gnt, sw_valid}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].pre_reset) do_reset();
            fill_mem(vecs[i].pat);
            run_job(vecs[i].req, vecs[i].delay, vecs[i].stray, vecs[i].hold,
                    vecs[i].exp_gnt, vecs[i].exp_err, vecs[i].pat);
        end

        // Reset in the middle of a stream abandons the job without a done.
        fill_mem(PAT_RAND);
        core_delay = 0;
        stray_addr = -1;
        req = 2'b01;
        @(negedge clk);
        check("rst_seq_grant", {30'd0, gnt}, {30'd0, rr_pick(2'b01, last_srv)});
        n = 0;
        while (rd_addr != 6'd20 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_seq_reached_addr20", {25'd0, sw_valid, rd_addr}, {25'd0, 1'b1, 6'd20});
        reset = 1'b1;
        #1;
        check("async_reset_immediate", {22'd0, gnt, sw_valid, rd_addr, done}, 32'd0);
        req = 2'b00;
        @(negedge clk);
        check("reset_held_idle", {27'd0, gnt, sw_valid, done}, 32'd0);
        reset    = 1'b0;
        last_srv = 1;
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (done != 2'b00 || sw_valid) dn++;
        end
        check("no_done_after_abandon", dn, 0);
        run_job(2'b01, 3, -1, 1'b0, rr_pick(2'b01, last_srv), 1'b0, PAT_RAND);

        for (int k = 0; k < 10; k++) begin
            r = 2'($urandom_range(1, 3));
            d = $urandom_range(2, 30);
            s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, LEN_REF - 1)) : -1;
            fill_mem(PAT_RAND);
            run_job(r, d, s, 1'b0, rr_pick(r, last_srv), 1'b0, PAT_RAND);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_job_arbiter.md
SW_JOB_ARBITER -- requirements
Module: sw_job_arbiter

Interface
REQ-001 Parameter WIDTH_SCORE, default 8, SW score width.
REQ-002 Parameter WIDTH_POS_REF, default 7, reference position width.
REQ-003 Parameter WIDTH_POS_QUERY, default 6, query position width.
REQ-004 Parameter LEN_REF, default 64, reference symbols per job.
REQ-005 Parameter LEN_QUERY, default 48, query symbols per job (LEN_QUERY <= LEN_REF).
REQ-006 Parameter TIMEOUT, default 4095, maximum cycles in WAIT before abort.
REQ-007 clk  input  1  clock, rising edge.
REQ-008 reset  input  1  reset, asynchronous, active-high.
REQ-009 req  input  2  per-requester job request, level, held until its done.
REQ-010 req_ref  input  2x2  per-requester reference symbol at rd_addr, combinational.
REQ-011 req_qry  input  2x2  per-requester query symbol at rd_addr, combinational.
REQ-012 gnt  output  2  one-hot grant, held from GRANT through RESP.
REQ-013 rd_addr  output  6  symbol index being streamed.
REQ-014 done  output  2  one-cycle completion pulse to the granted requester.
REQ-015 err  output  1  qualifies done: 1 = timeout abort, result invalid.
REQ-016 res_max / res_pos_ref / res_pos_query  output  WIDTH_SCORE / WIDTH_POS_REF / WIDTH_POS_QUERY  result, valid with done.
REQ-017 sw_valid, sw_data_ref[1:0], sw_data_query[1:0]  output  SW core input stream.
REQ-018 sw_finish, sw_max, sw_pos_ref, sw_pos_query  input  SW core result.

Function
REQ-019 States IDLE, GRANT, STREAM, GAP, WAIT, RESP; one-hot or binary at implementer's choice.
REQ-020 IDLE: if req != 0, latch winner into gnt, go GRANT; else stay.
REQ-021 Arbitration round-robin: last-served requester has lowest priority; after reset requester 0 has priority.
REQ-022 Simultaneous req=2'b11: grant the non-last-served requester; req on the granted side is ignored until RESP ends.
REQ-023 GRANT: one cycle, rd_addr=0, sw_valid=0; next STREAM.
REQ-024 STREAM: sw_valid=1 for exactly LEN_REF consecutive cycles, rd_addr 0..LEN_REF-1, incrementing each cycle.
REQ-025 STREAM: sw_data_ref = req_ref[granted]; sw_data_query = req_qry[granted] while rd_addr < LEN_QUERY, else 2'b00.
REQ-026 After rd_addr = LEN_REF-1: go GAP; sw_valid=0 for at least one cycle so the core leaves its input phase.
REQ-027 GAP: one cycle, clear watchdog counter, go WAIT.
REQ-028 WAIT: sw_valid=0; watchdog increments each cycle.
REQ-029 WAIT, sw_finish=1: capture sw_max/sw_pos_ref/sw_pos_query into res_*, err=0, go RESP.
REQ-030 WAIT, watchdog = TIMEOUT without sw_finish: res_* = 0, err=1, go RESP.
REQ-031 sw_finish while not in WAIT is ignored.
REQ-032 RESP: done[granted]=1 for one cycle; update last-served; clear gnt; go IDLE.
REQ-033 res_* and err hold their values until the next RESP.
REQ-034 A requester dropping req mid-job does not abort the job; done is still pulsed.
REQ-035 Job latency GRANT-entry to done = 1 + LEN_REF + 1 + (finish wait) + 1 cycles.

Reset
REQ-036 Reset assertion at any time returns to IDLE within the same cycle, abandoning any job with no done.
REQ-037 Reset values: gnt=0, done=0, err=0, res_*=0, rd_addr=0, sw_valid=0, sw_data_*=0, watchdog=0, last-served=requester 1.
REQ-038 The SW core shares reset; no handshake on reset is required.

Structure
REQ-039 Shared package sw_pkg holds state enum, LEN_REF, LEN_QUERY, score/position widths, and symbol encoding (A/C/G/T = 0..3).
REQ-040 Round-robin selection lives in sub-module sw_rr_arb2 (req[1:0], last[0:0] -> gnt[1:0], combinational).
REQ-041 rd_addr counter and watchdog are separate registers; no memories inside the block.

Verification
REQ-042 Single job: req=01, ref all 2'b00, query all 2'b00, model finish at 3075 cycles -> sw_valid high exactly 64 cycles, done=01 once, res = model values, err=0.
REQ-043 Contention: req=11 from reset -> gnt=01 first, then gnt=10 at the next job; with req held 11 grants alternate 01,10,01.
REQ-044 Query gating: ref symbol = rd_addr[1:0], query = 2'b11 -> sw_data_query=3 for rd_addr 0..47, 0 for 48..63.
REQ-045 Timeout: model never asserts sw_finish -> done after TIMEOUT WAIT cycles, err=1, res_max=0, next job accepted.
REQ-046 Reset mid-STREAM at rd_addr=20 -> next cycle gnt=0, sw_valid=0, no done; new req restarts at rd_addr=0.
REQ-047 Stray sw_finish during STREAM -> ignored; result captured only from finish in WAIT.
